interrupt_responder: RTL and testbench
======================================

Name: interrupt_responder

Overview:
CPU-side end of the interrupt/int_reply handshake driven by the SoC interrupt controller.
- Samples the interrupt request and decides whether it may be taken.
- Waits for an instruction boundary, then performs machine-mode trap entry: mepc, mcause, mstatus.MIE/MPIE and a fetch redirect.
- Raises int_reply and holds it until the controller drops interrupt.
- Also handles mret and owns the three trap CSRs it updates.

Parameters:
XLEN, 32, datapath width
MCAUSE_TIMER, 32'h80000007, mcause written for a timer interrupt
MCAUSE_EXT, 32'h8000000B, mcause written for any non-timer interrupt

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
interrupt  in  1  request level from the interrupt controller
int_istimer  in  1  valid while interrupt=1; 1 = timer source
int_reply  out  1  acknowledge level to the interrupt controller
insn_boundary  in  1  core is between instructions this cycle; safe to trap
pc_next  in  XLEN  address of the next unexecuted instruction
mtvec  in  XLEN  trap vector, direct mode only
mie_mtie  in  1  timer interrupt enable
mie_meie  in  1  external interrupt enable
mret  in  1  one-cycle pulse: core executing mret (only at a boundary)
trap_redirect  out  1  one-cycle pulse: fetch from trap_target
trap_target  out  XLEN  mtvec on trap entry, mepc on mret
csr_we  in  1  CSR write strobe
csr_sel  in  2  0 = mstatus, 1 = mepc, 2 = mcause, 3 = none
csr_wdata  in  XLEN  CSR write data
csr_rdata  out  XLEN  combinational read of the csr_sel register
irq_busy  out  1  state is not IDLE; debug/perf visibility

Behaviour:
- Reset (async, rst=0): all of the following go to 0 and state = IDLE:
  - outputs: int_reply, trap_redirect, trap_target
  - registers: mepc, mcause, MIE, MPIE
  - synchronisers: int_s, tmr_s
- Input registering: interrupt → int_s and int_istimer → tmr_s, one flop each.
- mstatus read format: bit3 = MIE, bit7 = MPIE, all other bits 0. Write updates only bits 3 and 7.
- mepc: bits [1:0] always read 0.
- Eligibility: en = MIE & (tmr_s ? mie_mtie : mie_meie).
- State machine, 2-bit encoding:
  - IDLE: if int_s & en → PEND.
  - PEND:
    - if !(int_s & en) → IDLE (request withdrawn or disabled); no side effects.
    - else if insn_boundary & !mret → trap entry; next state REPLY.
  - Trap entry, all registered on the same edge:
    - mepc ← {pc_next[XLEN-1:2], 2'b00}
    - mcause ← tmr_s ? MCAUSE_TIMER : MCAUSE_EXT
    - MPIE ← MIE, MIE ← 0
    - trap_target ← mtvec, trap_redirect ← 1 for exactly one cycle
    - int_reply ← 1
  - REPLY: hold int_reply = 1 until int_s = 0, then int_reply ← 0, → IDLE.
    - A new request is never evaluated in REPLY, so at most one trap per handshake.
- Latency: interrupt rises before edge E0 → int_s at E0 → PEND at E1. With insn_boundary=1 in the cycle after E1, trap_redirect and int_reply are high after E2.
- mret (any state): MIE ← MPIE, MPIE ← 1, trap_target ← mepc, trap_redirect pulse.
  - If mret and a trap-entry condition coincide, mret wins. The trap waits for a later boundary, re-checking en against the restored MIE.
- CSR write collision: if a CSR write hits the same cycle as trap entry or mret, trap entry/mret wins for the fields it updates. CSR write still applies to fields not touched by that event.
- A CSR write clearing MIE while in PEND → IDLE next cycle.
- In REPLY, the trap is already committed; MIE changes do not affect the handshake.
- int_reply and trap_redirect are registered outputs, never combinational from inputs.
- Reset mid-handshake: int_reply drops asynchronously. The controller shares the system reset, so both sides restart at IDLE.

Decomposition:
- Shared package holds:
  - CSR select codes (CSR_MSTATUS=0, CSR_MEPC=1, CSR_MCAUSE=2)
  - mstatus bit positions (MSTATUS_MIE=3, MSTATUS_MPIE=7)
  - MCAUSE_TIMER / MCAUSE_EXT constants
  - state encoding (IDLE, PEND, REPLY)
- Optional sub-module: irq_trap_csr, holding mepc/mcause/MIE/MPIE, the write-priority logic and the read mux. The FSM remains in interrupt_responder.

Test Plan:
1. MIE=1, mie_mtie=1; timer interrupt, insn_boundary held 1, pc_next=0x100 → after E2:
   - trap_redirect pulse with trap_target=mtvec
   - mepc=0x100, mcause=0x80000007, MIE=0, MPIE=1
   - int_reply=1 until one edge after interrupt falls, then 0
2. MIE=0; external interrupt held 20 cycles → int_reply stays 0, no redirect.
   - Then CSR write mstatus=0x8 → trap taken; mcause=0x8000000B.
3. MIE=1, interrupt pending, insn_boundary low for 5 cycles → stays in PEND, no side effects. Boundary asserted → trap on the next edge.
4. Request pending in PEND with mret and insn_boundary in the same cycle (MPIE=1):
   - mret redirect to mepc, MIE=1
   - trap entry at the next boundary with mepc = new pc_next
5. Trap entry coincides with a CSR write of mepc=0xDEAD0000 → mepc holds the trap value. A later mret redirects to it.
6. rst low while in REPLY → int_reply=0 immediately, state IDLE, all CSRs 0. After release, interrupt=0 → no activity.

Source files
------------

// File: rtl/interrupt_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// interrupt_responder_pkg : shared CSR codes, mstatus bits, mcause values, FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
package interrupt_responder_pkg;

  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MEPC    = 2'd1;
  localparam logic [1:0] CSR_MCAUSE  = 2'd2;
  localparam logic [1:0] CSR_NONE    = 2'd3;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam logic [31:0] MCAUSE_TIMER = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_EXT   = 32'h8000_000B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_REPLY = 2'd2
  } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/interrupt_responder_csr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_trap_csr : mepc / mcause / mstatus.{MIE,MPIE} with event-over-write priority
// Revision: 1.0
// ---------------------------------------------------------------------------
module irq_trap_csr #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  MCAUSE_TIMER = XLEN'(interrupt_responder_pkg::MCAUSE_TIMER),
  parameter logic [XLEN-1:0]  MCAUSE_EXT   = XLEN'(interrupt_responder_pkg::MCAUSE_EXT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_take,
  input  logic            trap_timer,
  input  logic [XLEN-1:0] pc_next,
  input  logic            mret,
  input  logic            csr_we,
  input  logic [1:0]      csr_sel,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            mie,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] csr_rdata
);
  import interrupt_responder_pkg::*;

  // mepc is word aligned, so only the upper bits are stored
  logic [XLEN-3:0] epc_q, epc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            unused_lsbs;

  assign unused_lsbs = ^{csr_wdata[1:0], pc_next[1:0]};

  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    epc_d    = epc_q;
    mcause_d = mcause_q;

    if (csr_we) begin
      case (csr_sel)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata[MSTATUS_MIE];
          mpie_d = csr_wdata[MSTATUS_MPIE];
        end
        CSR_MEPC:   epc_d    = csr_wdata[XLEN-1:2];
        CSR_MCAUSE: mcause_d = csr_wdata;
        default:    ;
      endcase
    end

    // Hardware events override a same-cycle software write on the fields they own
    if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (trap_take) begin
      epc_d    = pc_next[XLEN-1:2];
      mcause_d = trap_timer ? MCAUSE_TIMER : MCAUSE_EXT;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      epc_q    <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      epc_q    <= epc_d;
      mcause_q <= mcause_d;
    end
  end

  assign mie  = mie_q;
  assign mepc = {epc_q, 2'b00};

  always_comb begin
    csr_rdata = '0;
    case (csr_sel)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mie_q;
        csr_rdata[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MEPC:   csr_rdata = {epc_q, 2'b00};
      CSR_MCAUSE: csr_rdata = mcause_q;
      default:    csr_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// interrupt_responder : interrupt/int_reply handshake, M-mode trap entry and mret
// Revision: 1.0
// ---------------------------------------------------------------------------
module interrupt_responder #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  MCAUSE_TIMER = XLEN'(interrupt_responder_pkg::MCAUSE_TIMER),
  parameter logic [XLEN-1:0]  MCAUSE_EXT   = XLEN'(interrupt_responder_pkg::MCAUSE_EXT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interrupt,
  input  logic            int_istimer,
  output logic            int_reply,
  input  logic            insn_boundary,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mie_mtie,
  input  logic            mie_meie,
  input  logic            mret,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target,
  input  logic            csr_we,
  input  logic [1:0]      csr_sel,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            irq_busy
);
  import interrupt_responder_pkg::*;

  irq_state_e      state_q, state_d;
  logic            int_s_q, tmr_s_q;
  logic            int_reply_q, int_reply_d;
  logic            trap_redirect_q, trap_redirect_d;
  logic [XLEN-1:0] trap_target_q, trap_target_d;
  logic            trap_take;
  logic            mie;
  logic [XLEN-1:0] mepc;
  logic            en;
  logic            req_ok;

  assign en     = mie & (tmr_s_q ? mie_mtie : mie_meie);
  assign req_ok = int_s_q & en;

  irq_trap_csr #(
    .XLEN         (XLEN),
    .MCAUSE_TIMER (MCAUSE_TIMER),
    .MCAUSE_EXT   (MCAUSE_EXT)
  ) u_csr (
    .clk        (clk),
    .rst        (rst),
    .trap_take  (trap_take),
    .trap_timer (tmr_s_q),
    .pc_next    (pc_next),
    .mret       (mret),
    .csr_we     (csr_we),
    .csr_sel    (csr_sel),
    .csr_wdata  (csr_wdata),
    .mie        (mie),
    .mepc       (mepc),
    .csr_rdata  (csr_rdata)
  );

  always_comb begin
    state_d         = state_q;
    int_reply_d     = int_reply_q;
    trap_redirect_d = 1'b0;
    trap_target_d   = trap_target_q;
    trap_take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_ok) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!req_ok) begin
          state_d = ST_IDLE;
        end else if (insn_boundary && !mret) begin
          trap_take       = 1'b1;
          state_d         = ST_REPLY;
          int_reply_d     = 1'b1;
          trap_redirect_d = 1'b1;
          trap_target_d   = mtvec;
        end
      end
      ST_REPLY: begin
        // Committed trap: only the controller dropping its request ends it
        if (!int_s_q) begin
          int_reply_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        int_reply_d = 1'b0;
      end
    endcase

    if (mret) begin
      trap_redirect_d = 1'b1;
      trap_target_d   = mepc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      int_s_q         <= 1'b0;
      tmr_s_q         <= 1'b0;
      int_reply_q     <= 1'b0;
      trap_redirect_q <= 1'b0;
      trap_target_q   <= '0;
    end else begin
      state_q         <= state_d;
      int_s_q         <= interrupt;
      tmr_s_q         <= int_istimer;
      int_reply_q     <= int_reply_d;
      trap_redirect_q <= trap_redirect_d;
      trap_target_q   <= trap_target_d;
    end
  end

  assign int_reply     = int_reply_q;
  assign trap_redirect = trap_redirect_q;
  assign trap_target   = trap_target_q;
  assign irq_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_interrupt_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_interrupt_responder : directed scenarios plus randomized run against a model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_interrupt_responder;

  localparam int XLEN = 32;
  localparam logic [1:0] SEL_MSTATUS = 2'd0;
  localparam logic [1:0] SEL_MEPC    = 2'd1;
  localparam logic [1:0] SEL_MCAUSE  = 2'd2;

  logic            clk = 1'b0;
  logic            rst;
  logic            interrupt, int_istimer, int_reply;
  logic            insn_boundary;
  logic [XLEN-1:0] pc_next, mtvec;
  logic            mie_mtie, mie_meie, mret;
  logic            trap_redirect;
  logic [XLEN-1:0] trap_target;
  logic            csr_we;
  logic [1:0]      csr_sel;
  logic [XLEN-1:0] csr_wdata, csr_rdata;
  logic            irq_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: "waiting" and "in handshake" flags plus architectural CSRs
  bit          m_int, m_tmr, m_waiting, m_handshake, m_mie, m_mpie, m_redirect;
  logic [31:0] m_mepc, m_mcause, m_target;

  interrupt_responder #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .interrupt     (interrupt),
    .int_istimer   (int_istimer),
    .int_reply     (int_reply),
    .insn_boundary (insn_boundary),
    .pc_next       (pc_next),
    .mtvec         (mtvec),
    .mie_mtie      (mie_mtie),
    .mie_meie      (mie_meie),
    .mret          (mret),
    .trap_redirect (trap_redirect),
    .trap_target   (trap_target),
    .csr_we        (csr_we),
    .csr_sel       (csr_sel),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .irq_busy      (irq_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_int = 0; m_tmr = 0; m_waiting = 0; m_handshake = 0;
    m_mie = 0; m_mpie = 0; m_redirect = 0;
    m_mepc = 0; m_mcause = 0; m_target = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_edge();
    bit allowed, take, n_mie, n_mpie;
    logic [31:0] n_mepc, n_mcause;
    allowed = m_int && m_mie && (m_tmr ? mie_mtie : mie_meie);
    take    = m_waiting && allowed && insn_boundary && !mret;
    n_mie = m_mie; n_mpie = m_mpie; n_mepc = m_mepc; n_mcause = m_mcause;
    if (csr_we && csr_sel == SEL_MSTATUS) begin n_mie = csr_wdata[3]; n_mpie = csr_wdata[7]; end
    if (csr_we && csr_sel == SEL_MEPC)    n_mepc = csr_wdata & 32'hFFFF_FFFC;
    if (csr_we && csr_sel == SEL_MCAUSE)  n_mcause = csr_wdata;
    if (mret) begin
      n_mie = m_mpie; n_mpie = 1;
      m_target = m_mepc;
    end else if (take) begin
      n_mepc = pc_next & 32'hFFFF_FFFC;
      n_mcause = m_tmr ? 32'h8000_0007 : 32'h8000_000B;
      n_mpie = m_mie; n_mie = 0;
      m_target = mtvec;
    end
    m_redirect = mret || take;
    if (m_handshake)      m_waiting = 0;
    else if (m_waiting)   m_waiting = allowed && !take;
    else                  m_waiting = allowed;
    m_handshake = take || (m_handshake && m_int);
    m_mie = n_mie; m_mpie = n_mpie; m_mepc = n_mepc; m_mcause = n_mcause;
    m_int = interrupt; m_tmr = int_istimer;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [1:0] sel, output logic [31:0] val);
    csr_we = 0;
    csr_sel = sel;
    #1;
    val = csr_rdata;
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
    csr_we = 1; csr_sel = sel; csr_wdata = data;
    tick();
    csr_we = 0; csr_sel = 2'd3;
  endtask

  task automatic idle_inputs();
    interrupt = 0; int_istimer = 0; insn_boundary = 0; pc_next = 0; mtvec = 32'h0000_3000;
    mie_mtie = 1; mie_meie = 1; mret = 0; csr_we = 0; csr_sel = 2'd3; csr_wdata = 0;
  endtask

  task automatic hard_reset();
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    n_checks++; if (int_reply !== 1'b0) $display("FAIL reset_int_reply got=%0b exp=0", int_reply); else n_pass++;
    n_checks++; if (trap_redirect !== 1'b0) $display("FAIL reset_redirect got=%0b exp=0", trap_redirect); else n_pass++;
    n_checks++; if (trap_target !== 32'h0) $display("FAIL reset_target got=%h exp=0", trap_target); else n_pass++;
    n_checks++; if (irq_busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", irq_busy); else n_pass++;
    read_csr(SEL_MSTATUS, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_mstatus got=%h exp=0", v); else n_pass++;
    read_csr(SEL_MEPC, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_mepc got=%h exp=0", v); else n_pass++;
    read_csr(SEL_MCAUSE, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_mcause got=%h exp=0", v); else n_pass++;
  endtask

  task automatic test_timer_trap();
    logic [31:0] v;
    hard_reset();
    csr_write(SEL_MSTATUS, 32'h8);
    interrupt = 1; int_istimer = 1; mie_mtie = 1; insn_boundary = 1;
    pc_next = 32'h100; mtvec = 32'h2000;
    tick();  // E0: request sampled
    tick();  // E1: pending
    n_checks++; if (irq_busy !== 1'b1 || trap_redirect !== 1'b0)
      $display("FAIL timer_pend busy=%0b redirect=%0b exp busy=1 redirect=0", irq_busy, trap_redirect); else n_pass++;
    tick();  // E2: trap entry
    n_checks++; if (trap_redirect !== 1'b1) $display("FAIL timer_redirect got=%0b exp=1", trap_redirect); else n_pass++;
    n_checks++; if (trap_target !== 32'h2000) $display("FAIL timer_target got=%h exp=2000", trap_target); else n_pass++;
    n_checks++; if (int_reply !== 1'b1) $display("FAIL timer_reply got=%0b exp=1", int_reply); else n_pass++;
    read_csr(SEL_MEPC, v);
    n_checks++; if (v !== 32'h100) $display("FAIL timer_mepc got=%h exp=100", v); else n_pass++;
    read_csr(SEL_MCAUSE, v);
    n_checks++; if (v !== 32'h8000_0007) $display("FAIL timer_mcause got=%h exp=80000007", v); else n_pass++;
    read_csr(SEL_MSTATUS, v);
    n_checks++; if (v !== 32'h80) $display("FAIL timer_mstatus got=%h exp=80", v); else n_pass++;
    tick();
    n_checks++; if (trap_redirect !== 1'b0 || int_reply !== 1'b1)
      $display("FAIL timer_hold redirect=%0b reply=%0b exp redirect=0 reply=1", trap_redirect, int_reply); else n_pass++;
    interrupt = 0;
    tick();
    n_checks++; if (int_reply !== 1'b1) $display("FAIL timer_reply_after_drop got=%0b exp=1", int_reply); else n_pass++;
    tick();
    n_checks++; if (int_reply !== 1'b0 || irq_busy !== 1'b0)
      $display("FAIL timer_release reply=%0b busy=%0b exp 0 0", int_reply, irq_busy); else n_pass++;
  endtask

  task automatic test_disabled();
    logic [31:0] v;
    int bad = 0;
    hard_reset();
    interrupt = 1; int_istimer = 0; mie_meie = 1; mie_mtie = 0; insn_boundary = 1; pc_next = 32'h300;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int_reply || trap_redirect || irq_busy) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL disabled_activity got=%0d cycles exp=0", bad); else n_pass++;
    csr_write(SEL_MSTATUS, 32'h8);
    for (int i = 0; i < 6 && trap_redirect !== 1'b1; i++) tick();
    n_checks++; if (trap_redirect !== 1'b1) $display("FAIL disabled_enable_trap redirect=%0b exp=1 (timeout)", trap_redirect); else n_pass++;
    n_checks++; if (int_reply !== 1'b1) $display("FAIL disabled_enable_reply got=%0b exp=1", int_reply); else n_pass++;
    read_csr(SEL_MCAUSE, v);
    n_checks++; if (v !== 32'h8000_000B) $display("FAIL disabled_mcause got=%h exp=8000000b", v); else n_pass++;
    interrupt = 0; insn_boundary = 0;
    tick(); tick();
    n_checks++; if (int_reply !== 1'b0) $display("FAIL disabled_release got=%0b exp=0", int_reply); else n_pass++;
  endtask

  task automatic test_boundary_wait();
    logic [31:0] v;
    int bad = 0;
    hard_reset();
    csr_write(SEL_MSTATUS, 32'h8);
    interrupt = 1; int_istimer = 0; mie_meie = 1; insn_boundary = 0; pc_next = 32'h440; mtvec = 32'h3000;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!irq_busy || int_reply || trap_redirect) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL boundary_wait_bad got=%0d cycles exp=0", bad); else n_pass++;
    read_csr(SEL_MSTATUS, v);
    n_checks++; if (v !== 32'h8) $display("FAIL boundary_wait_mstatus got=%h exp=8", v); else n_pass++;
    insn_boundary = 1;
    tick();
    n_checks++; if (trap_redirect !== 1'b1 || int_reply !== 1'b1 || trap_target !== 32'h3000)
      $display("FAIL boundary_trap redirect=%0b reply=%0b target=%h exp 1 1 3000", trap_redirect, int_reply, trap_target); else n_pass++;
    read_csr(SEL_MEPC, v);
    n_checks++; if (v !== 32'h440) $display("FAIL boundary_mepc got=%h exp=440", v); else n_pass++;
    interrupt = 0; insn_boundary = 0;
    tick(); tick();
  endtask

  task automatic test_mret_collision();
    logic [31:0] v;
    hard_reset();
    csr_write(SEL_MSTATUS, 32'h88);
    csr_write(SEL_MEPC, 32'h400);
    interrupt = 1; int_istimer = 0; mie_meie = 1; insn_boundary = 0; mtvec = 32'h3000;
    tick(); tick();
    n_checks++; if (irq_busy !== 1'b1) $display("FAIL mret_pend_busy got=%0b exp=1", irq_busy); else n_pass++;
    mret = 1; insn_boundary = 1; pc_next = 32'h500;
    tick();
    mret = 0; pc_next = 32'h600;
    n_checks++; if (trap_redirect !== 1'b1 || trap_target !== 32'h400 || int_reply !== 1'b0)
      $display("FAIL mret_wins redirect=%0b target=%h reply=%0b exp 1 400 0", trap_redirect, trap_target, int_reply); else n_pass++;
    read_csr(SEL_MSTATUS, v);
    n_checks++; if (v !== 32'h88) $display("FAIL mret_mstatus got=%h exp=88", v); else n_pass++;
    tick();
    n_checks++; if (trap_redirect !== 1'b1 || trap_target !== 32'h3000 || int_reply !== 1'b1)
      $display("FAIL mret_then_trap redirect=%0b target=%h reply=%0b exp 1 3000 1", trap_redirect, trap_target, int_reply); else n_pass++;
    read_csr(SEL_MEPC, v);
    n_checks++; if (v !== 32'h600) $display("FAIL mret_then_trap_mepc got=%h exp=600", v); else n_pass++;
    interrupt = 0; insn_boundary = 0;
    tick(); tick();
  endtask

  task automatic test_csr_collision();
    logic [31:0] v;
    hard_reset();
    csr_write(SEL_MSTATUS, 32'h8);
    interrupt = 1; int_istimer = 0; mie_meie = 1; insn_boundary = 0;
    tick(); tick();
    insn_boundary = 1; pc_next = 32'h700;
    csr_we = 1; csr_sel = SEL_MEPC; csr_wdata = 32'hDEAD_0000;
    tick();
    csr_we = 0;
    read_csr(SEL_MEPC, v);
    n_checks++; if (v !== 32'h700) $display("FAIL collide_mepc got=%h exp=700", v); else n_pass++;
    interrupt = 0; insn_boundary = 0;
    tick(); tick();
    n_checks++; if (irq_busy !== 1'b0) $display("FAIL collide_idle got=%0b exp=0", irq_busy); else n_pass++;
    mret = 1; insn_boundary = 1;
    tick();
    mret = 0; insn_boundary = 0;
    n_checks++; if (trap_redirect !== 1'b1 || trap_target !== 32'h700)
      $display("FAIL collide_mret redirect=%0b target=%h exp 1 700", trap_redirect, trap_target); else n_pass++;
    read_csr(SEL_MSTATUS, v);
    n_checks++; if (v !== 32'h88) $display("FAIL collide_mret_mstatus got=%h exp=88", v); else n_pass++;
  endtask

  task automatic test_reset_mid_reply();
    logic [31:0] v;
    int bad = 0;
    hard_reset();
    csr_write(SEL_MSTATUS, 32'h8);
    interrupt = 1; int_istimer = 1; mie_mtie = 1; insn_boundary = 1; pc_next = 32'h800;
    tick(); tick(); tick();
    n_checks++; if (int_reply !== 1'b1) $display("FAIL midreset_pre_reply got=%0b exp=1", int_reply); else n_pass++;
    rst = 0;
    model_reset();
    #1;
    n_checks++; if (int_reply !== 1'b0 || irq_busy !== 1'b0 || trap_target !== 32'h0 || trap_redirect !== 1'b0)
      $display("FAIL midreset_outputs reply=%0b busy=%0b target=%h redirect=%0b exp all 0",
               int_reply, irq_busy, trap_target, trap_redirect); else n_pass++;
    read_csr(SEL_MSTATUS, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midreset_mstatus got=%h exp=0", v); else n_pass++;
    read_csr(SEL_MEPC, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midreset_mepc got=%h exp=0", v); else n_pass++;
    read_csr(SEL_MCAUSE, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midreset_mcause got=%h exp=0", v); else n_pass++;
    interrupt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (int_reply || trap_redirect || irq_busy) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL midreset_after_release got=%0d active cycles exp=0", bad); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] v, exp_ms;
    hard_reset();
    csr_write(SEL_MSTATUS, 32'h8);
    mtvec = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) interrupt = !interrupt;
      if (!interrupt) int_istimer = 1'($urandom_range(0, 1));
      insn_boundary = 1'($urandom_range(0, 1));
      mret = ($urandom_range(0, 9) == 0);
      if (mret) insn_boundary = 1;
      pc_next = $urandom;
      mie_mtie = ($urandom_range(0, 7) != 0);
      mie_meie = ($urandom_range(0, 7) != 0);
      csr_we = ($urandom_range(0, 9) == 0);
      csr_sel = 2'($urandom_range(0, 3));
      csr_wdata = $urandom;
      tick();
      n_checks++; if (int_reply !== m_handshake) $display("FAIL rand_reply cyc=%0d got=%0b exp=%0b", i, int_reply, m_handshake); else n_pass++;
      n_checks++; if (trap_redirect !== m_redirect) $display("FAIL rand_redirect cyc=%0d got=%0b exp=%0b", i, trap_redirect, m_redirect); else n_pass++;
      n_checks++; if (trap_target !== m_target) $display("FAIL rand_target cyc=%0d got=%h exp=%h", i, trap_target, m_target); else n_pass++;
      n_checks++; if (irq_busy !== (m_waiting || m_handshake))
        $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", i, irq_busy, (m_waiting || m_handshake)); else n_pass++;
      exp_ms = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      read_csr(SEL_MSTATUS, v);
      n_checks++; if (v !== exp_ms) $display("FAIL rand_mstatus cyc=%0d got=%h exp=%h", i, v, exp_ms); else n_pass++;
      read_csr(SEL_MEPC, v);
      n_checks++; if (v !== m_mepc) $display("FAIL rand_mepc cyc=%0d got=%h exp=%h", i, v, m_mepc); else n_pass++;
      read_csr(SEL_MCAUSE, v);
      n_checks++; if (v !== m_mcause) $display("FAIL rand_mcause cyc=%0d got=%h exp=%h", i, v, m_mcause); else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    test_reset();
    test_timer_trap();
    test_disabled();
    test_boundary_wait();
    test_mret_collision();
    test_csr_collision();
    test_reset_mid_reply();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
